// File: rtl/lsu_pkg.sv
// Load/store unit types: access size, controller state, lane widths, alignment rule.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
package lsu_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // A request that can never touch memory: reserved size or an address
    // not aligned to the access size.
    function automatic logic is_bad_req(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/port_define.sv
// Shared bus widths for the core datapath and the data-memory port.
// Latency: n/a (constants only).
// Backpressure: n/a.
package port_define;
    localparam int RegBus = 32;   // register / data word width
    localparam int DmAddr = 10;   // data-memory word-index width (4 KiB)
endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response bundle plus the data-memory port of the LSU.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready handshake; responses and memory port have none.
interface lsu_if;
    logic                              req_valid;
    logic                              req_we;
    logic [1:0]                        req_size;
    logic                              req_sign;
    logic [31:0]                       req_addr;
    logic [31:0]                       req_wdata;
    logic                              req_ready;
    logic                              resp_valid;
    logic [31:0]                       resp_rdata;
    logic                              resp_err;
    logic                              DM_read;
    logic                              DM_write;
    logic [port_define::DmAddr-1:0]    DM_address;
    logic [port_define::RegBus-1:0]    DM_in;
    logic [port_define::RegBus-1:0]    DM_out;

    // slave: the LSU itself (takes requests, drives the memory port)
    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, DM_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
               DM_read, DM_write, DM_address, DM_in
    );
    // master: pipeline + memory environment around the LSU
    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, DM_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               DM_read, DM_write, DM_address, DM_in
    );
endinterface

// File: rtl/lsu_lane_merge.sv
// Lane logic: extract+extend a load lane from a memory word, merge store data into it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mem_word/lane/size/sign/wdata in; load_data (extended), store_word (merged) out.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] mem_word,
    input  logic [1:0]        lane,
    input  size_e             size,
    input  logic              sign,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] store_word
);
    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    // Little-endian: lane 0 is bits 7:0; a half lives in the low or high 16 bits.
    always_comb begin
        byte_sel   = mem_word[{lane, 3'b000} +: BYTE_W];
        half_sel   = mem_word[{lane[1], 4'b0000} +: HALF_W];
        load_data  = '0;
        store_word = mem_word;
        case (size)
            SZ_BYTE: begin
                load_data = {{(WORD_W-BYTE_W){sign & byte_sel[BYTE_W-1]}}, byte_sel};
                store_word[{lane, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_data = {{(WORD_W-HALF_W){sign & half_sel[HALF_W-1]}}, half_sel};
                store_word[{lane[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            end
            SZ_WORD: begin
                load_data  = mem_word;
                store_word = wdata;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time into a single-port data memory.
// Latency: bad req +1, load / word store +2, byte/half store (read-modify-write) +3.
// Backpressure: req_ready only in IDLE; responses are single-cycle pulses, no stall.
// Ports: clk, rst (sync, active-high), bus (lsu_if.slave: request, response, DM port).
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    localparam int AW = port_define::DmAddr;

    state_e             state_q, state_d;
    logic [AW+1:0]      addr_q, addr_d;      // only bits that reach memory; upper ones wrap
    size_e              size_q, size_d;
    logic               sign_q, sign_d;
    logic               we_q, we_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               dm_read_q, dm_read_d;
    logic               dm_write_q, dm_write_d;
    logic [AW-1:0]      dm_addr_q, dm_addr_d;
    logic [WORD_W-1:0]  dm_in_q, dm_in_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [WORD_W-1:0]  resp_rdata_q, resp_rdata_d;
    logic [WORD_W-1:0]  load_data, store_word;
    size_e              req_size_e;
    logic               unused_addr_hi;

    assign req_size_e     = size_e'(bus.req_size);
    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    lsu_lane_merge u_lane_merge (
        .mem_word   (bus.DM_out),
        .lane       (addr_q[1:0]),
        .size       (size_q),
        .sign       (sign_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Memory-port and response flops are loaded for the state being entered,
    // so every output is registered and is zero outside RD/WR/DONE.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        sign_d       = sign_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        dm_read_d    = 1'b0;
        dm_write_d   = 1'b0;
        dm_addr_d    = '0;
        dm_in_d      = '0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr[AW+1:0];
                    size_d  = req_size_e;
                    sign_d  = bus.req_sign;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    if (is_bad_req(req_size_e, bus.req_addr[1:0])) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_we && req_size_e == SZ_WORD) begin
                        state_d    = WR;
                        dm_write_d = 1'b1;
                        dm_addr_d  = bus.req_addr[AW+1:2];
                        dm_in_d    = bus.req_wdata;
                    end else begin
                        // loads and sub-word stores both start with a read
                        state_d   = RD;
                        dm_read_d = 1'b1;
                        dm_addr_d = bus.req_addr[AW+1:2];
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d    = WR;
                    dm_write_d = 1'b1;
                    dm_addr_d  = addr_q[AW+1:2];
                    dm_in_d    = store_word;
                end else begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            WR: begin
                state_d      = DONE;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;   // DONE always returns
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= SZ_BYTE;
            sign_q       <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            dm_read_q    <= 1'b0;
            dm_write_q   <= 1'b0;
            dm_addr_q    <= '0;
            dm_in_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            dm_read_q    <= dm_read_d;
            dm_write_q   <= dm_write_d;
            dm_addr_q    <= dm_addr_d;
            dm_in_q      <= dm_in_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    // Gate strobes with rst so a write in flight cannot land in the reset cycle.
    assign bus.DM_read    = dm_read_q & ~rst;
    assign bus.DM_write   = dm_write_q & ~rst;
    assign bus.DM_address = dm_addr_q;
    assign bus.DM_in      = dm_in_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule
